// File: rtl/div2_engine.sv
// Start/Ack division responder: reads a 16-bit dividend and an 8-bit divisor from data memory,
// computes floor(dividend*256/divisor) by restoring division and writes the 24-bit quotient back.
module div2_engine #(
    parameter int ADDR_W   = 8,
    parameter int OPA_ADDR = 0,
    parameter int RES_ADDR = 4,
    parameter int ROUND    = 0
) (
    input  logic              Clk,
    input  logic              Reset,
    input  logic              Start,
    output logic              Ack,
    output logic [ADDR_W-1:0] mem_addr,
    input  logic [7:0]        mem_rd_data,
    output logic              mem_wr_en,
    output logic [7:0]        mem_wr_data
);

    localparam int                NBITS    = (ROUND != 0) ? 25 : 24;
    localparam logic [4:0]        LAST_BIT = 5'(NBITS - 1);
    localparam logic [ADDR_W-1:0] OPA0     = ADDR_W'(OPA_ADDR);
    localparam logic [ADDR_W-1:0] OPA1     = ADDR_W'(OPA_ADDR + 1);
    localparam logic [ADDR_W-1:0] OPA2     = ADDR_W'(OPA_ADDR + 2);
    localparam logic [ADDR_W-1:0] RES0     = ADDR_W'(RES_ADDR);
    localparam logic [ADDR_W-1:0] RES1     = ADDR_W'(RES_ADDR + 1);
    localparam logic [ADDR_W-1:0] RES2     = ADDR_W'(RES_ADDR + 2);

    typedef enum logic [3:0] {
        S_IDLE, S_ARMED, S_RD0, S_RD1, S_RD2, S_DIV, S_WR0, S_WR1, S_WR2, S_DONE
    } state_t;

    state_t            state_q;
    logic [7:0]        dvd_hi_q, dvd_lo_q, dsr_q;
    logic [23:0]       n_q;
    logic [8:0]        rem_q;
    logic [23:0]       q_q;
    logic [4:0]        cnt_q;
    logic [15:0]       res_lo_q;
    logic              ack_q, wr_en_q;
    logic [ADDR_W-1:0] addr_q;
    logic [7:0]        wdata_q;

    logic [9:0]  rem_shift, diff;
    logic        q_bit;
    logic [8:0]  rem_d;
    logic [23:0] q_d, res_d;
    logic [24:0] rounded;

    // One restoring step: shift the next dividend bit into the remainder and trial-subtract.
    // In the ROUND build the 25th step yields the half-LSB, which is added instead of shifted in.
    always_comb begin
        rem_shift = {rem_q, n_q[23]};
        diff      = rem_shift - {2'b00, dsr_q};
        q_bit     = (rem_shift >= {2'b00, dsr_q});
        rem_d     = q_bit ? diff[8:0] : rem_shift[8:0];
        q_d       = {q_q[22:0], q_bit};
        rounded   = {1'b0, q_q} + {24'd0, q_bit};
        if (ROUND != 0) begin
            res_d = rounded[24] ? 24'hFF_FFFF : rounded[23:0];
        end else begin
            res_d = q_d;
        end
    end

    always_ff @(posedge Clk) begin
        if (Reset) begin
            state_q  <= S_IDLE;
            dvd_hi_q <= '0;
            dvd_lo_q <= '0;
            dsr_q    <= '0;
            n_q      <= '0;
            rem_q    <= '0;
            q_q      <= '0;
            cnt_q    <= '0;
            res_lo_q <= '0;
            ack_q    <= 1'b0;
            wr_en_q  <= 1'b0;
            addr_q   <= '0;
            wdata_q  <= '0;
        end else begin
            // NOTE: strobes default low here; each state below re-asserts them only where needed.
            wr_en_q <= 1'b0;
            ack_q   <= 1'b0;
            case (state_q)
                S_IDLE: if (Start) state_q <= S_ARMED;
                S_ARMED: begin
                    if (!Start) begin
                        addr_q  <= OPA0;
                        state_q <= S_RD0;
                    end
                end
                S_RD0: begin
                    dvd_hi_q <= mem_rd_data;
                    addr_q   <= OPA1;
                    state_q  <= S_RD1;
                end
                S_RD1: begin
                    dvd_lo_q <= mem_rd_data;
                    addr_q   <= OPA2;
                    state_q  <= S_RD2;
                end
                S_RD2: begin
                    dsr_q <= mem_rd_data;
                    n_q   <= {dvd_hi_q, dvd_lo_q, 8'h00};
                    rem_q <= '0;
                    q_q   <= '0;
                    cnt_q <= '0;
                    if (mem_rd_data == 8'h00) begin
                        res_lo_q <= 16'hFFFF;
                        wr_en_q  <= 1'b1;
                        addr_q   <= RES0;
                        wdata_q  <= 8'hFF;
                        state_q  <= S_WR0;
                    end else begin
                        addr_q  <= '0;
                        state_q <= S_DIV;
                    end
                end
                S_DIV: begin
                    n_q   <= {n_q[22:0], 1'b0};
                    rem_q <= rem_d;
                    q_q   <= q_d;
                    cnt_q <= cnt_q + 5'd1;
                    if (cnt_q == LAST_BIT) begin
                        res_lo_q <= res_d[15:0];
                        wr_en_q  <= 1'b1;
                        addr_q   <= RES0;
                        wdata_q  <= res_d[23:16];
                        state_q  <= S_WR0;
                    end
                end
                S_WR0: begin
                    wr_en_q <= 1'b1;
                    addr_q  <= RES1;
                    wdata_q <= res_lo_q[15:8];
                    state_q <= S_WR1;
                end
                S_WR1: begin
                    wr_en_q <= 1'b1;
                    addr_q  <= RES2;
                    wdata_q <= res_lo_q[7:0];
                    state_q <= S_WR2;
                end
                S_WR2: begin
                    addr_q  <= '0;
                    wdata_q <= '0;
                    state_q <= S_DONE;
                end
                S_DONE: begin
                    if (Start) state_q <= S_ARMED;
                    else       ack_q   <= 1'b1;
                end
                default: state_q <= S_IDLE;
            endcase
        end
    end

    assign Ack         = ack_q;
    assign mem_addr    = addr_q;
    assign mem_wr_en   = wr_en_q;
    assign mem_wr_data = wdata_q;

endmodule
